pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_if.sv | 23 ++
 rtl/pc_fetch_unit.sv | 107 ++++++++++
 tb/tb_pc_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-unit bus: redirect from the CPU, instruction-memory port and the
// instruction valid/ready handshake towards the CPU.
interface pc_fetch_if;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready;

  modport master (
    input  redirect_valid, redirect_addr, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_o, pc_o
  );

  modport slave (
    output redirect_valid, redirect_addr, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_o, pc_o
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential fetches to a
// one-cycle instruction memory and buffers {inst, pc} pairs for the CPU.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst,
  pc_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic          r_inflight;
  logic          r_drop;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_inst_o;
  logic [31:0]   r_pc_o;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_req;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_rptr_nxt;
  logic [31:0]   w_head_inst;
  logic [31:0]   w_head_pc;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.inst_ready & ~bus.redirect_valid;
  // A redirect flushes everything, including a response arriving this cycle.
  assign w_push  = r_inflight & ~r_drop & ~bus.redirect_valid;

  // Credits: buffered entries plus the one in flight, less what leaves now.
  assign w_used = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_req  = ~rst & ~bus.redirect_valid & (w_used < LIMIT);

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rptr_nxt  = r_rptr + AW'(w_pop);

  // Next head of the FIFO; only the pushed word can land on an empty slot.
  always_comb begin
    w_head_inst = r_mem_inst[w_rptr_nxt];
    w_head_pc   = r_mem_pc[w_rptr_nxt];
    if (w_push && (r_wptr == w_rptr_nxt)) begin
      w_head_inst = bus.imem_rdata;
      w_head_pc   = r_req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_inst_o   <= '0;
      r_pc_o     <= '0;
    end else begin
      r_inflight <= w_req;
      r_drop     <= bus.redirect_valid & r_inflight;
      if (w_req) begin
        r_req_addr <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        r_fetch_pc <= {bus.redirect_addr[31:2], 2'b00};
        r_rptr     <= '0;
        r_wptr     <= '0;
        r_count    <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        r_rptr  <= w_rptr_nxt;
        r_count <= w_count_nxt;
        // Outputs hold their last value while the FIFO is empty.
        if (w_count_nxt != '0) begin
          r_inst_o <= w_head_inst;
          r_pc_o   <= w_head_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wptr] <= bus.imem_rdata;
      r_mem_pc[r_wptr]   <= r_req_addr;
    end
  end

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = r_fetch_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst_o     = r_inst_o;
  assign bus.pc_o       = r_pc_o;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand sequences for
// redirect/wrap/reset corners, then random traffic against a queue model.
module tb_pc_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_if bus();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: every issued, unflushed request becomes an item visible two
  // cycles after issue; the CPU consumes them in program order.
  typedef struct {
    logic [31:0] pc;
    int          vis;
  } item_t;
  item_t       q[$];
  logic [31:0] exp_fetch;
  logic [31:0] held_pc, held_inst;
  logic        last_req;
  logic [31:0] last_addr;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_inst;

  typedef struct {
    logic        do_rst;
    logic        rv;
    logic [31:0] ra;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_fetch = RESET_PC;
    held_pc   = 32'h0;
    held_inst = 32'h0;
    last_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst_inst_o", bus.inst_o, 32'h0);
    chk("rst_pc_o", bus.pc_o, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.imem_rdata = $urandom();
  endtask

  task automatic cycle(input logic rv, input logic [31:0] ra, input logic rdy);
    logic ev, pop, ereq;
    bus.redirect_valid = rv;
    bus.redirect_addr  = ra;
    bus.inst_ready     = rdy;
    #2;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.inst_valid;
    s_pc    = bus.pc_o;
    s_inst  = bus.inst_o;
    ev = (q.size() > 0) && (q[0].vis <= cyc);
    chk("inst_valid", 32'(s_valid), 32'(ev));
    if (ev) begin
      chk("pc_o", s_pc, q[0].pc);
      chk("inst_o", s_inst, q[0].pc ^ K);
      held_pc   = q[0].pc;
      held_inst = q[0].pc ^ K;
    end else begin
      chk("pc_o_hold", s_pc, held_pc);
      chk("inst_o_hold", s_inst, held_inst);
    end
    pop  = ev && rdy && !rv;
    ereq = !rv && ((q.size() - (pop ? 1 : 0)) < DEPTH);
    chk("imem_req", 32'(s_req), 32'(ereq));
    if (s_req && ereq) chk("imem_addr", s_addr, exp_fetch);
    if (rv) begin
      q.delete();
      exp_fetch = {ra[31:2], 2'b00};
    end else begin
      if (pop) void'(q.pop_front());
      if (ereq) begin
        q.push_back('{exp_fetch, cyc + 2});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    last_req  = s_req;
    last_addr = s_addr;
    @(posedge clk);
    #1;
    bus.imem_rdata = last_req ? (last_addr ^ K) : $urandom();
    cyc++;
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.imem_rdata     = 32'h0;
    model_reset();

    //            rst rv ra  rdy ereq eaddr       evalid epc
    tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8};

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].do_rst) do_reset();
      cycle(tbl[i].rv, tbl[i].ra, tbl[i].rdy);
      chk("tbl_req", 32'(s_req), 32'(tbl[i].ereq));
      if (tbl[i].ereq) chk("tbl_addr", s_addr, tbl[i].eaddr);
      chk("tbl_valid", 32'(s_valid), 32'(tbl[i].evalid));
      if (tbl[i].evalid) chk("tbl_pc", s_pc, tbl[i].epc);
    end

    // Redirect with a request in flight and a buffered entry.
    cycle(1'b1, 32'h0000_0103, 1'b1);
    chk("redir_no_req", 32'(s_req), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("redir_addr", s_addr, 32'h0000_0100);
    chk("redir_req", 32'(s_req), 32'h1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("redir_gap", 32'(s_valid), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("redir_pc", s_pc, 32'h0000_0100);

    // Back-to-back redirects: the later one wins.
    cycle(1'b1, 32'h0000_0040, 1'b1);
    cycle(1'b1, 32'h0000_0080, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("b2b_addr", s_addr, 32'h0000_0080);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("b2b_pc", s_pc, 32'h0000_0080);

    // PC wraps through zero.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
    cycle(1'b0, 32'h0, 1'b1);
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b1);
    chk("wrap_pc2", s_pc, 32'h0000_0000);

    // Reset mid-stream with the FIFO full.
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("full_valid", 32'(s_valid), 32'h1);
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
    chk("rst_restart_addr", s_addr, RESET_PC);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("rst_restart_pc", s_pc, RESET_PC);

    for (int i = 0; i < 2000; i++) begin
      logic        rv, rdy;
      logic [31:0] ra;
      if ($urandom_range(0, 299) == 0) do_reset();
      rv  = ($urandom_range(0, 9) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom());
      rdy = ($urandom_range(0, 3) != 0);
      cycle(rv, ra, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
